// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_if
// Brief   : Operand/result valid-ready bundle for the sequential ALU.
// Rev     : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Negative;
    logic             Carry;
    logic             Overflow;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, Zero, Negative, Carry, Overflow
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Brief   : Registered 3-bit-opcode ALU with NZCV flags, iterative shifts and
//           valid/ready handshakes on both sides.
// Rev     : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);
    localparam int c_SHW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;

    localparam logic [c_SHW-1:0] c_CNT_ONE = c_SHW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;
    logic [c_SHW-1:0] r_count;
    logic             r_shr;

    logic             w_accept;
    logic             w_is_shift;
    logic [c_SHW-1:0] w_amt;
    logic             w_a_msb;
    logic             w_b_msb;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_shifted;

    assign bus.in_ready = (r_state == c_IDLE) && !reset;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_is_shift   = bus.ALUControl[2] & bus.ALUControl[1];
    assign w_amt        = bus.SrcB[c_SHW-1:0];
    assign w_a_msb      = bus.SrcA[WIDTH-1];
    assign w_b_msb      = bus.SrcB[WIDTH-1];
    assign w_sum        = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
    assign w_diff       = {1'b0, bus.SrcA} - {1'b0, bus.SrcB};
    // Signed less-than: differing signs decide directly, else the difference sign does.
    assign w_slt        = (w_a_msb != w_b_msb) ? w_a_msb : w_diff[WIDTH-1];
    assign w_shifted    = r_shr ? (r_result >> 1) : (r_result << 1);

    always_comb begin
        w_alu   = bus.SrcA;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.ALUControl)
            c_OP_AND: w_alu = bus.SrcA & bus.SrcB;
            c_OP_OR:  w_alu = bus.SrcA | bus.SrcB;
            c_OP_ADD: begin
                w_alu   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (w_a_msb == w_b_msb) && (w_sum[WIDTH-1] != w_a_msb);
            end
            c_OP_SUB: begin
                w_alu   = w_diff[WIDTH-1:0];
                w_carry = ~w_diff[WIDTH];
                w_ovf   = (w_a_msb != w_b_msb) && (w_diff[WIDTH-1] != w_a_msb);
            end
            c_OP_XOR: w_alu = bus.SrcA ^ bus.SrcB;
            c_OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            // Shifts load the unshifted operand; SHIFT state does the rest.
            default:  w_alu = bus.SrcA;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_is_shift && (w_amt != '0)) ? c_SHIFT : c_DONE;
                end
            end
            c_SHIFT: begin
                if (r_count == c_CNT_ONE) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_count  <= '0;
            r_shr    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_result <= w_alu;
                        r_zero   <= (w_alu == '0);
                        r_neg    <= w_alu[WIDTH-1];
                        r_carry  <= w_carry;
                        r_ovf    <= w_ovf;
                        r_count  <= w_is_shift ? w_amt : '0;
                        r_shr    <= bus.ALUControl[0];
                    end
                end
                c_SHIFT: begin
                    r_result <= w_shifted;
                    r_zero   <= (w_shifted == '0);
                    r_neg    <= w_shifted[WIDTH-1];
                    r_count  <= r_count - c_CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (r_state == c_DONE);
    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;
    assign bus.Negative  = r_neg;
    assign bus.Carry     = r_carry;
    assign bus.Overflow  = r_ovf;
endmodule
`default_nettype wire
